// File: rtl/stage_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the Pillar RV32I core.
// Instruction class sets which stages run; an illegal opcode parks the core in HALT.
module stage_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_i,
  input  logic [31:0] ir_i,
  input  logic        mem_ack_i,
  output logic [2:0]  stage_o,
  output logic        ir_we_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_ifetch_o,
  output logic        wd_q_o,
  output logic        pc_we_o,
  output logic        halted_o,
  output logic [31:0] retire_cnt_o
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } stage_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  stage_e      stage_q;
  logic        pend_q;
  logic        ld_q, st_q, br_q;
  logic        ir_we_q, wd_q_q, pc_we_q, halted_q;
  logic [31:0] cnt_q;

  logic [6:0] opc;
  logic       is_ld, is_st, is_br, legal, rd_nz;
  logic       unused_ir;

  assign opc       = ir_i[6:0];
  assign is_ld     = (opc == OP_L);
  assign is_st     = (opc == OP_S);
  assign is_br     = (opc == OP_B);
  assign legal     = is_ld | is_st | is_br | (opc == OP_R) | (opc == OP_I) |
                     (opc == OP_U) | (opc == OP_JAL) | (opc == OP_JALR);
  assign rd_nz     = |ir_i[11:7];
  assign unused_ir = ^ir_i[31:12];

  // Fetch request follows run_i until raised, then pend_q holds it to the ack.
  assign mem_req_o    = ((stage_q == ST_FETCH) && (run_i || pend_q)) || (stage_q == ST_MEM);
  assign mem_ifetch_o = (stage_q == ST_FETCH) && (run_i || pend_q);
  assign mem_we_o     = (stage_q == ST_MEM) && st_q;

  assign stage_o      = stage_q;
  assign ir_we_o      = ir_we_q;
  assign wd_q_o       = wd_q_q;
  assign pc_we_o      = pc_we_q;
  assign halted_o     = halted_q;
  assign retire_cnt_o = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q  <= ST_FETCH;
      pend_q   <= 1'b0;
      ld_q     <= 1'b0;
      st_q     <= 1'b0;
      br_q     <= 1'b0;
      ir_we_q  <= 1'b0;
      wd_q_q   <= 1'b0;
      pc_we_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= 32'd0;
    end else begin
      ir_we_q <= 1'b0;
      wd_q_q  <= 1'b0;
      pc_we_q <= 1'b0;
      cnt_q   <= cnt_q + {31'd0, pc_we_q};
      case (stage_q)
        ST_FETCH: begin
          if (mem_req_o) begin
            if (mem_ack_i) begin
              stage_q <= ST_DECODE;
              ir_we_q <= 1'b1;
              pend_q  <= 1'b0;
            end else begin
              pend_q  <= 1'b1;
            end
          end
        end
        ST_DECODE: begin
          if (legal) begin
            stage_q <= ST_EXEC;
            ld_q    <= is_ld;
            st_q    <= is_st;
            br_q    <= is_br;
            // Branches retire in EXEC, so their strobe is armed here.
            pc_we_q <= is_br;
          end else begin
            stage_q  <= ST_HALT;
            halted_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (ld_q || st_q) begin
            stage_q <= ST_MEM;
          end else if (br_q) begin
            stage_q <= ST_FETCH;
          end else begin
            stage_q <= ST_WB;
            wd_q_q  <= rd_nz;
            pc_we_q <= 1'b1;
          end
        end
        ST_MEM: begin
          if (mem_ack_i) begin
            pc_we_q <= 1'b1;
            if (st_q) begin
              stage_q <= ST_FETCH;
            end else begin
              stage_q <= ST_WB;
              wd_q_q  <= rd_nz;
            end
          end
        end
        ST_WB:   stage_q <= ST_FETCH;
        ST_HALT: stage_q <= ST_HALT;
        default: stage_q <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_ctrl.sv
// Bench for stage_ctrl: memory responder plus monitor popping expected retires
// and memory transactions from scoreboard queues, driven by directed programs.
module tb_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_i = 1'b0;
  logic [31:0] ir_i = 32'd0;
  logic        mem_ack_i = 1'b0;
  logic [2:0]  stage_o;
  logic        ir_we_o, mem_req_o, mem_we_o, mem_ifetch_o;
  logic        wd_q_o, pc_we_o, halted_o;
  logic [31:0] retire_cnt_o;

  stage_ctrl dut (
    .clk(clk), .reset(reset), .run_i(run_i), .ir_i(ir_i), .mem_ack_i(mem_ack_i),
    .stage_o(stage_o), .ir_we_o(ir_we_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_ifetch_o(mem_ifetch_o), .wd_q_o(wd_q_o), .pc_we_o(pc_we_o),
    .halted_o(halted_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] stg; logic wd; logic [31:0] cnt; int lat; } ret_t;
  typedef struct { logic ifetch; logic we; int len; } req_t;

  ret_t        ret_q[$];
  req_t        req_q[$];
  logic [31:0] prog[$];
  logic [2:0]  stage_log[$];

  int n_tot = 0, n_pass = 0;
  int flat = 0, dlat = 0;
  logic spur = 1'b0;
  int cyc = 0, ack_cyc = 0, wcnt = 0, req_len = 0;
  logic prev_we = 1'b0, prev_if = 1'b0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic bad(string nm, logic [31:0] act);
    n_tot++;
    $display("FAIL %s: got 0x%0h", nm, act);
  endtask

  // Memory responder and monitor share one negedge process so the ack decision
  // is visible to the monitor in the same cycle.
  always @(negedge clk) begin
    ret_t r;
    req_t q;
    int   lat;
    cyc++;
    if (reset) begin
      mem_ack_i = 1'b0;
      wcnt = 0;
      req_len = 0;
    end else begin
      if (mem_req_o) begin
        lat = mem_ifetch_o ? flat : dlat;
        if (wcnt >= lat) begin
          mem_ack_i = 1'b1;
          wcnt = 0;
          if (mem_ifetch_o && prog.size() > 0) ir_i = prog.pop_front();
        end else begin
          mem_ack_i = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack_i = spur;
        wcnt = 0;
      end

      stage_log.push_back(stage_o);
      if (pc_we_o) begin
        if (ret_q.size() == 0) bad("retire_unexpected", 32'(stage_o));
        else begin
          r = ret_q.pop_front();
          chk("retire_stage", 32'(stage_o), 32'(r.stg));
          chk("retire_wd", 32'(wd_q_o), 32'(r.wd));
          chk("retire_cnt", retire_cnt_o, r.cnt);
          chk("retire_latency", 32'(cyc - ack_cyc), 32'(r.lat));
        end
      end else if (wd_q_o) bad("wd_without_pc_we", 32'(stage_o));

      if (mem_req_o) begin
        req_len++;
        if (req_len > 1 && (mem_we_o !== prev_we || mem_ifetch_o !== prev_if))
          bad("req_attr_unstable", {30'd0, mem_we_o, mem_ifetch_o});
        prev_we = mem_we_o;
        prev_if = mem_ifetch_o;
        if (mem_ack_i) begin
          if (req_q.size() == 0) bad("req_unexpected", {30'd0, mem_we_o, mem_ifetch_o});
          else begin
            q = req_q.pop_front();
            chk("req_ifetch", 32'(mem_ifetch_o), 32'(q.ifetch));
            chk("req_we", 32'(mem_we_o), 32'(q.we));
            chk("req_len", 32'(req_len), 32'(q.len));
          end
          if (mem_ifetch_o) ack_cyc = cyc;
          req_len = 0;
        end
      end else req_len = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run_i = 1'b0; spur = 1'b0;
    ret_q.delete(); req_q.delete(); prog.delete();
    exp_cnt = 32'd0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push_instr(logic [31:0] ir, logic [2:0] stg, logic wd, int lat,
                            logic is_mem, logic we);
    ret_t r;
    req_t q;
    prog.push_back(ir);
    q.ifetch = 1'b1; q.we = 1'b0; q.len = flat + 1;
    req_q.push_back(q);
    if (is_mem) begin
      q.ifetch = 1'b0; q.we = we; q.len = dlat + 1;
      req_q.push_back(q);
    end
    r.stg = stg; r.wd = wd; r.cnt = exp_cnt; r.lat = lat;
    ret_q.push_back(r);
    exp_cnt++;
  endtask

  task automatic drain(int budget);
    for (int i = 0; i < budget; i++) begin
      if (ret_q.size() == 0 && req_q.size() == 0) break;
      tick();
    end
    if (ret_q.size() != 0 || req_q.size() != 0)
      bad("drain_timeout", 32'(ret_q.size() + req_q.size()));
    for (int i = 0; i < 3; i++) tick();
  endtask

  // Keeps run_i high until n instructions have been loaded into the IR.
  task automatic run_n(int n, int budget);
    int loaded = 0;
    run_i = 1'b1;
    for (int i = 0; i < budget && loaded < n; i++) begin
      tick();
      if (ir_we_o) loaded++;
    end
    run_i = 1'b0;
    if (loaded != n) bad("run_timeout", 32'(loaded));
    drain(200);
  endtask

  initial begin
    int busy;
    logic [2:0] exp_seq [5];
    exp_seq[0] = 3'd0; exp_seq[1] = 3'd1; exp_seq[2] = 3'd2;
    exp_seq[3] = 3'd4; exp_seq[4] = 3'd0;

    // Reset state with run_i low: idle, no request.
    do_reset();
    chk("rst_stage", 32'(stage_o), 32'd0);
    chk("rst_strobes", {27'd0, ir_we_o, wd_q_o, pc_we_o, halted_o, mem_we_o}, 32'd0);
    chk("rst_cnt", retire_cnt_o, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("idle_no_req", {30'd0, mem_req_o, mem_ifetch_o}, 32'd0);
      tick();
    end

    // add x3,x1,x2 with zero-wait memory.
    flat = 0; dlat = 0;
    push_instr(32'h002081B3, 3'd4, 1'b1, 3, 1'b0, 1'b0);
    stage_log.delete();
    run_n(1, 50);
    for (int i = 0; i < 5; i++) chk("add_stage_seq", 32'(stage_log[i]), 32'(exp_seq[i]));
    chk("add_cnt", retire_cnt_o, 32'd1);

    // lw x3 with three data wait cycles: four request cycles, eight in total.
    dlat = 3;
    push_instr(32'h0000A183, 3'd4, 1'b1, 7, 1'b1, 1'b0);
    run_n(1, 50);
    chk("load_cnt", retire_cnt_o, 32'd2);

    // Store then branch from a fresh reset.
    do_reset();
    dlat = 0;
    push_instr(32'h0020A023, 3'd0, 1'b0, 4, 1'b1, 1'b1);
    push_instr(32'h00208463, 3'd2, 1'b0, 2, 1'b0, 1'b0);
    stage_log.delete();
    run_n(2, 60);
    chk("st_br_cnt", retire_cnt_o, 32'd2);
    busy = 0;
    for (int i = 6; i < stage_log.size(); i++)
      if (stage_log[i] == 3'd3 || stage_log[i] == 3'd4) busy++;
    chk("branch_no_mem_wb", 32'(busy), 32'd0);

    // addi x0 with a slow fetch; run_i drops while the request is pending.
    flat = 3;
    push_instr(32'h00100013, 3'd4, 1'b0, 3, 1'b0, 1'b0);
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    chk("held_req_after_run_drop", 32'(mem_req_o), 32'd1);
    drain(50);
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req_o) busy++;
      tick();
    end
    chk("no_fetch_after_run_drop", 32'(busy), 32'd0);
    chk("addi_x0_cnt", retire_cnt_o, exp_cnt);

    // Reset while a fetch is stalled.
    flat = 100;
    run_i = 1'b1;
    tick(); tick(); tick();
    chk("stall_req", {30'd0, mem_req_o, mem_ifetch_o}, 32'd3);
    chk("stall_cnt", retire_cnt_o, 32'd3);
    reset = 1'b1; run_i = 1'b0;
    tick();
    chk("midrst_req", 32'(mem_req_o), 32'd0);
    chk("midrst_cnt", retire_cnt_o, 32'd0);
    chk("midrst_stage", 32'(stage_o), 32'd0);
    do_reset();

    // Illegal opcode halts; run_i high and spurious acks must not wake it.
    flat = 0;
    prog.push_back(32'h0000007F);
    begin
      req_t q;
      q.ifetch = 1'b1; q.we = 1'b0; q.len = 1;
      req_q.push_back(q);
    end
    run_i = 1'b1; spur = 1'b1;
    for (int i = 0; i < 20 && !halted_o; i++) tick();
    chk("halt_flag", 32'(halted_o), 32'd1);
    chk("halt_stage", 32'(stage_o), 32'd7);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_o || ir_we_o || pc_we_o || wd_q_o || stage_o != 3'd7) busy++;
      tick();
    end
    chk("halt_quiet", 32'(busy), 32'd0);
    chk("halt_req_q_empty", 32'(req_q.size()), 32'd0);
    do_reset();
    chk("post_halt_stage", 32'(stage_o), 32'd0);
    chk("post_halt_flag", 32'(halted_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
